trap_controller: RTL and testbench

Sequences machine-mode trap entry and return for the in-order core. It watches retiring instructions at writeback and the three interrupt lines, drains the pipeline when an interrupt must be taken, and emits one atomic CSR update (mepc/mcause/mtval/mstatus). It also emits a pipeline flush and a held PC redirect to the fetch PC-select logic. It sits beside the CSR register file and is the only writer of the trap CSRs.

---
 rtl/csr_pkg.sv | 28 ++
 rtl/trap_target.sv | 43 ++++
 rtl/trap_controller.sv | 134 +++++++++++++
 tb/tb_trap_controller.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared types and constants for machine-mode trap sequencing.
// Pure declarations; no logic, no latency, no flow control.
package csr_pkg;

  typedef enum logic [1:0] {
    KIND_NORMAL = 2'd0,
    KIND_ECALL  = 2'd1,
    KIND_MRET   = 2'd2,
    KIND_EXCEPT = 2'd3
  } trap_kind_t;

  localparam logic [3:0] ECALL_M   = 4'd11;
  localparam logic [3:0] IRQ_EXT   = 4'd11;
  localparam logic [3:0] IRQ_SW    = 4'd3;
  localparam logic [3:0] IRQ_TIMER = 4'd7;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_DRAIN    = 2'd1;
  localparam state_t ST_TRAP     = 2'd2;
  localparam state_t ST_REDIRECT = 2'd3;

endpackage

// File: rtl/trap_target.sv
// Computes trap/MRET redirect target, mcause and mstatus from the latched trap.
// Purely combinational, zero latency; no flow control.
module trap_target
  import csr_pkg::*;
(
  input  logic [1:0]  kind,
  input  logic        irq,
  input  logic [3:0]  code,
  input  logic [63:0] mtvec_q,
  input  logic [63:0] mepc_q,
  input  logic [63:0] mstatus_q,
  input  logic [63:0] last_mcause,
  output logic [63:0] redirect_pc,
  output logic [63:0] new_mcause,
  output logic [63:0] new_mstatus
);

  always_comb begin
    redirect_pc = {mtvec_q[63:2], 2'b00};
    new_mstatus = mstatus_q;
    new_mcause  = {60'b0, code};
    if (!irq && kind == KIND_MRET) begin
      // mcause has no read port here; the last value we wrote is the live one.
      redirect_pc                                  = mepc_q;
      new_mcause                                   = last_mcause;
      new_mstatus[MSTATUS_MIE]                     = mstatus_q[MSTATUS_MPIE];
      new_mstatus[MSTATUS_MPIE]                    = 1'b1;
      new_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO]   = 2'b11;
    end else begin
      new_mstatus[MSTATUS_MPIE]                    = mstatus_q[MSTATUS_MIE];
      new_mstatus[MSTATUS_MIE]                     = 1'b0;
      new_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO]   = 2'b11;
      if (irq) begin
        new_mcause = {1'b1, 59'b0, code};
        if (mtvec_q[1:0] == 2'b01)
          redirect_pc = redirect_pc + {58'b0, code, 2'b00};
      end else if (kind == KIND_ECALL) begin
        new_mcause = {60'b0, ECALL_M};
      end
    end
  end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode trap entry/return sequencer: sync trap in TRAP one cycle after retire, irqs drain first.
// Redirect is held (valid and pc stable) until redirect_ready; csr_we/flush pulse once per trap.
module trap_controller
  import csr_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        trint,
  input  logic        swint,
  input  logic        exint,
  input  logic [63:0] mstatus_q,
  input  logic [63:0] mie_q,
  input  logic [63:0] mtvec_q,
  input  logic [63:0] mepc_q,
  input  logic        wb_valid,
  input  logic [1:0]  wb_kind,
  input  logic [63:0] wb_pc,
  input  logic [3:0]  wb_cause,
  input  logic [63:0] wb_tval,
  input  logic        pipe_empty,
  input  logic [63:0] fetch_pc,
  input  logic        redirect_ready,
  output logic        hold_fetch,
  output logic        flush,
  output logic        redirect_valid,
  output logic [63:0] redirect_pc,
  output logic        csr_we,
  output logic [63:0] new_mepc,
  output logic [63:0] new_mcause,
  output logic [63:0] new_mtval,
  output logic [63:0] new_mstatus
);

  state_t      state, state_nxt;
  logic [1:0]  kind_q;
  logic        irq_q;
  logic [3:0]  code_q;
  logic [63:0] epc_q, tval_q, pc_hold, last_mcause, last_mtval;
  logic [63:0] tgt_pc, tgt_cause, tgt_mstatus;
  logic [3:0]  irq_code;
  logic        sync_evt, irq_pend, take_sync, take_irq, in_trap, in_redir, is_mret;
  logic        unused_mie;

  assign unused_mie = ^{mie_q[63:12], mie_q[10:8], mie_q[6:4], mie_q[2:0]};

  assign sync_evt = wb_valid && (wb_kind != KIND_NORMAL);
  assign irq_pend = mstatus_q[MSTATUS_MIE] &&
                    ((exint && mie_q[11]) || (swint && mie_q[3]) || (trint && mie_q[7]));

  always_comb begin
    irq_code = IRQ_TIMER;
    if (swint && mie_q[3])  irq_code = IRQ_SW;
    if (exint && mie_q[11]) irq_code = IRQ_EXT;
  end

  assign take_sync = ((state == ST_IDLE) || (state == ST_DRAIN)) && sync_evt;
  assign take_irq  = (state == ST_DRAIN) && !sync_evt && pipe_empty && irq_pend;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (sync_evt) state_nxt = ST_TRAP;
                   else if (irq_pend) state_nxt = ST_DRAIN;
      ST_DRAIN:    if (take_sync || take_irq) state_nxt = ST_TRAP;
                   else if (pipe_empty) state_nxt = ST_IDLE;
      ST_TRAP:     state_nxt = redirect_ready ? ST_IDLE : ST_REDIRECT;
      ST_REDIRECT: if (redirect_ready) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      kind_q      <= 2'd0;
      irq_q       <= 1'b0;
      code_q      <= 4'd0;
      epc_q       <= 64'd0;
      tval_q      <= 64'd0;
      pc_hold     <= 64'd0;
      last_mcause <= 64'd0;
      last_mtval  <= 64'd0;
    end else begin
      state <= state_nxt;
      if (take_sync) begin
        kind_q <= wb_kind;
        irq_q  <= 1'b0;
        code_q <= wb_cause;
        epc_q  <= wb_pc;
        tval_q <= (wb_kind == KIND_EXCEPT) ? wb_tval : 64'd0;
      end else if (take_irq) begin
        kind_q <= KIND_NORMAL;
        irq_q  <= 1'b1;
        code_q <= irq_code;
        epc_q  <= fetch_pc;
        tval_q <= 64'd0;
      end
      // Snapshot the target so a held redirect cannot move if CSRs change.
      if (in_trap) begin
        pc_hold     <= tgt_pc;
        last_mcause <= tgt_cause;
        last_mtval  <= new_mtval;
      end
    end
  end

  trap_target u_target (
    .kind        (kind_q),
    .irq         (irq_q),
    .code        (code_q),
    .mtvec_q     (mtvec_q),
    .mepc_q      (mepc_q),
    .mstatus_q   (mstatus_q),
    .last_mcause (last_mcause),
    .redirect_pc (tgt_pc),
    .new_mcause  (tgt_cause),
    .new_mstatus (tgt_mstatus)
  );

  assign in_trap  = (state == ST_TRAP);
  assign in_redir = (state == ST_REDIRECT);
  assign is_mret  = !irq_q && (kind_q == KIND_MRET);

  assign hold_fetch     = (state != ST_IDLE);
  assign flush          = in_trap;
  assign csr_we         = in_trap;
  assign redirect_valid = in_trap || in_redir;
  assign redirect_pc    = in_trap ? tgt_pc : (in_redir ? pc_hold : 64'd0);
  assign new_mepc       = in_trap ? (is_mret ? mepc_q : epc_q) : 64'd0;
  assign new_mcause     = in_trap ? tgt_cause : 64'd0;
  assign new_mtval      = in_trap ? (is_mret ? last_mtval : tval_q) : 64'd0;
  assign new_mstatus    = in_trap ? tgt_mstatus : 64'd0;

endmodule

// File: tb/tb_trap_controller.sv
// Directed bench for trap_controller; expected CSR writes go to a scoreboard queue,
// a negedge monitor pops and compares on every csr_we.
module tb_trap_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        trint, swint, exint;
  logic [63:0] mstatus_q, mie_q, mtvec_q, mepc_q;
  logic        wb_valid;
  logic [1:0]  wb_kind;
  logic [63:0] wb_pc;
  logic [3:0]  wb_cause;
  logic [63:0] wb_tval;
  logic        pipe_empty;
  logic [63:0] fetch_pc;
  logic        redirect_ready;
  logic        hold_fetch, flush, redirect_valid, csr_we;
  logic [63:0] redirect_pc, new_mepc, new_mcause, new_mtval, new_mstatus;

  typedef struct {
    logic [63:0] mepc;
    logic [63:0] mcause;
    logic [63:0] mtval;
    logic [63:0] mstatus;
    logic [63:0] rpc;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  logic        prev_rv = 1'b0;
  logic [63:0] prev_pc = 64'd0;

  always #5 clk = ~clk;

  trap_controller dut (
    .clk            (clk),
    .reset          (reset),
    .trint          (trint),
    .swint          (swint),
    .exint          (exint),
    .mstatus_q      (mstatus_q),
    .mie_q          (mie_q),
    .mtvec_q        (mtvec_q),
    .mepc_q         (mepc_q),
    .wb_valid       (wb_valid),
    .wb_kind        (wb_kind),
    .wb_pc          (wb_pc),
    .wb_cause       (wb_cause),
    .wb_tval        (wb_tval),
    .pipe_empty     (pipe_empty),
    .fetch_pc       (fetch_pc),
    .redirect_ready (redirect_ready),
    .hold_fetch     (hold_fetch),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .csr_we         (csr_we),
    .new_mepc       (new_mepc),
    .new_mcause     (new_mcause),
    .new_mtval      (new_mtval),
    .new_mstatus    (new_mstatus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] mepc, input logic [63:0] mcause,
                      input logic [63:0] mtval, input logic [63:0] mstatus,
                      input logic [63:0] rpc);
    exp_t e;
    e.mepc = mepc; e.mcause = mcause; e.mtval = mtval; e.mstatus = mstatus; e.rpc = rpc;
    exp_q.push_back(e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_hold"},    {63'd0, hold_fetch},     64'd0);
    check({tag, "_flush"},   {63'd0, flush},          64'd0);
    check({tag, "_rv"},      {63'd0, redirect_valid}, 64'd0);
    check({tag, "_we"},      {63'd0, csr_we},         64'd0);
    check({tag, "_rpc"},     redirect_pc,             64'd0);
    check({tag, "_mepc"},    new_mepc,                64'd0);
    check({tag, "_mcause"},  new_mcause,              64'd0);
    check({tag, "_mtval"},   new_mtval,               64'd0);
    check({tag, "_mstatus"}, new_mstatus,             64'd0);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset) begin
      prev_rv = 1'b0;
    end else begin
      if (csr_we || flush)
        check("flush_eq_we", {63'd0, flush}, {63'd0, csr_we});
      if (csr_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_we", {63'd0, csr_we}, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_mepc",    new_mepc,    e.mepc);
          check("sb_mcause",  new_mcause,  e.mcause);
          check("sb_mtval",   new_mtval,   e.mtval);
          check("sb_mstatus", new_mstatus, e.mstatus);
          check("sb_rpc",     redirect_pc, e.rpc);
          check("sb_rv",      {63'd0, redirect_valid}, 64'd1);
        end
      end
      if (redirect_valid && prev_rv)
        check("rpc_stable", redirect_pc, prev_pc);
      prev_rv = redirect_valid;
      prev_pc = redirect_pc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    trint = 0; swint = 0; exint = 0;
    mstatus_q = 64'd0; mie_q = 64'd0; mtvec_q = 64'h8000_0400; mepc_q = 64'd0;
    wb_valid = 0; wb_kind = 2'd0; wb_pc = 64'd0; wb_cause = 4'd0; wb_tval = 64'd0;
    pipe_empty = 0; fetch_pc = 64'd0; redirect_ready = 1;
    tick();
    tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // ECALL
    mstatus_q = 64'h8;
    wb_valid = 1; wb_kind = 2'd1; wb_pc = 64'h8000_0100;
    push(64'h8000_0100, 64'd11, 64'd0, 64'h1880, 64'h8000_0400);
    tick();
    check("ecall_lat", {63'd0, csr_we}, 64'd1);
    wb_valid = 0;
    tick();
    check("ecall_one", {63'd0, csr_we}, 64'd0);

    // MRET
    mstatus_q = 64'h1880; mepc_q = 64'h8000_0104;
    wb_valid = 1; wb_kind = 2'd2; wb_pc = 64'h8000_0300;
    push(64'h8000_0104, 64'd11, 64'd0, 64'h1888, 64'h8000_0104);
    tick();
    check("mret_flush", {63'd0, flush}, 64'd1);
    wb_valid = 0;
    tick();
    check("mret_flush_off", {63'd0, flush}, 64'd0);

    // External interrupt with 3-cycle drain
    mstatus_q = 64'h8; mie_q = 64'h800; exint = 1; pipe_empty = 0; fetch_pc = 64'h8000_0200;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("drain_hold", {63'd0, hold_fetch}, 64'd1);
      check("drain_no_we", {63'd0, csr_we}, 64'd0);
      if (i < 2) tick();
    end
    pipe_empty = 1;
    push(64'h8000_0200, 64'h8000_0000_0000_000B, 64'd0, 64'h1880, 64'h8000_0400);
    tick();
    check("irq_trap", {63'd0, csr_we}, 64'd1);
    exint = 0; pipe_empty = 0;
    tick();
    mstatus_q = 64'h1880; mie_q = 64'd0;
    tick();

    // EXCEPT retires during DRAIN; sw interrupt deferred until MIE returns
    mstatus_q = 64'h8; mie_q = 64'h8; swint = 1;
    tick();
    check("sw_drain", {63'd0, hold_fetch}, 64'd1);
    wb_valid = 1; wb_kind = 2'd3; wb_pc = 64'h8000_0300; wb_cause = 4'd2; wb_tval = 64'hdead;
    push(64'h8000_0300, 64'd2, 64'hdead, 64'h1880, 64'h8000_0400);
    tick();
    check("exc_trap", {63'd0, csr_we}, 64'd1);
    wb_valid = 0;
    tick();
    mstatus_q = 64'h1880;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("masked_idle", {63'd0, hold_fetch}, 64'd0);
    end
    mstatus_q = 64'h1888; pipe_empty = 1; fetch_pc = 64'h8000_0304;
    push(64'h8000_0304, 64'h8000_0000_0000_0003, 64'd0, 64'h1880, 64'h8000_0400);
    tick();
    check("sw_drain2", {63'd0, hold_fetch}, 64'd1);
    tick();
    check("sw_trap", {63'd0, csr_we}, 64'd1);
    swint = 0;
    tick();
    mstatus_q = 64'h1880; pipe_empty = 0; mie_q = 64'd0;
    tick();

    // Vectored timer interrupt with redirect backpressure
    mtvec_q = 64'h8000_0401; mstatus_q = 64'h8; mie_q = 64'h80; trint = 1;
    pipe_empty = 1; fetch_pc = 64'h8000_0500; redirect_ready = 0;
    push(64'h8000_0500, 64'h8000_0000_0000_0007, 64'd0, 64'h1880, 64'h8000_041C);
    tick();
    tick();
    check("vec_rv0", {63'd0, redirect_valid}, 64'd1);
    check("vec_rpc0", redirect_pc, 64'h8000_041C);
    trint = 0;
    tick();
    check("vec_rv1", {63'd0, redirect_valid}, 64'd1);
    check("vec_we1", {63'd0, csr_we}, 64'd0);
    mstatus_q = 64'h1880; mtvec_q = 64'h8000_0400; mie_q = 64'd0; pipe_empty = 0;
    tick();
    check("vec_rv2", {63'd0, redirect_valid}, 64'd1);
    check("vec_rpc2", redirect_pc, 64'h8000_041C);
    redirect_ready = 1;
    tick();
    check("vec_rv_off", {63'd0, redirect_valid}, 64'd0);

    // Reset during REDIRECT
    redirect_ready = 0;
    wb_valid = 1; wb_kind = 2'd1; wb_pc = 64'h8000_0600;
    push(64'h8000_0600, 64'd11, 64'd0, 64'h1800, 64'h8000_0400);
    tick();
    wb_valid = 0;
    tick();
    check("redir_before_rst", {63'd0, redirect_valid}, 64'd1);
    reset = 1;
    tick();
    check_all_zero("rst_redir");
    reset = 0; redirect_ready = 1;
    tick();
    check("post_rst_idle", {63'd0, hold_fetch}, 64'd0);
    tick();
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
